// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S transmit serializer and its sample FIFO.
package i2s_pkg;

  localparam int unsigned SAMPLE_W           = 16;
  localparam int unsigned DEFAULT_SLOT_BITS  = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/stereo_sample_fifo.sv
// Order-preserving FIFO of stereo sample pairs; pointers wrap modulo Depth, occupancy kept apart.
module stereo_sample_fifo import i2s_pkg::*; #(
  parameter int unsigned Depth = DEFAULT_FIFO_DEPTH,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  sample_pair_t    wdata_i,
  input  logic            pop_i,
  output sample_pair_t    rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  sample_pair_t    mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
    cnt_d   = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: buffers stereo pairs, latches one pair per frame into a shadow and
// shifts it out MSB first with registered word-select, data and frame markers.
module i2s_tx_serializer import i2s_pkg::*; #(
  parameter int unsigned SLOT_BITS  = DEFAULT_SLOT_BITS,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                BCLK,
  input  logic                RESET_N,
  input  logic [SAMPLE_W-1:0] SAMPLE_L,
  input  logic [SAMPLE_W-1:0] SAMPLE_R,
  input  logic                SAMPLE_VALID,
  output logic                SAMPLE_READY,
  output logic                DAC_LR_CLK,
  output logic                DAC_DATA,
  output logic                FRAME_START,
  output logic                UNDERRUN
);

  localparam int unsigned FrameLen = 2 * SLOT_BITS;
  localparam int unsigned CntW     = $clog2(FrameLen);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BitIdxW  = $clog2(SAMPLE_W);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rdy_en_q, rdy_en_d;
  sample_pair_t        shadow_q, shadow_d;
  logic                lr_q, lr_d;
  logic                data_q, data_d;
  logic                fs_q, fs_d;
  logic                ur_q, ur_d;

  sample_pair_t        in_pair, fifo_rdata;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FifoCntW-1:0] fifo_count;
  logic                unused_fifo_count;

  logic                wrap, right_slot;
  logic [CntW-1:0]     pos;
  logic [SAMPLE_W-1:0] word;
  logic [BitIdxW-1:0]  bit_idx;

  assign in_pair.left      = SAMPLE_L;
  assign in_pair.right     = SAMPLE_R;
  assign unused_fifo_count = ^fifo_count;

  stereo_sample_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (BCLK),
    .rst_ni  (RESET_N),
    .push_i  (fifo_push),
    .wdata_i (in_pair),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Ready is held low through reset and for the edge that releases it.
  assign SAMPLE_READY = rdy_en_q && !fifo_full;
  assign fifo_push    = SAMPLE_VALID && SAMPLE_READY;

  always_comb begin
    wrap     = (cnt_q == CntW'(FrameLen - 1));
    cnt_d    = wrap ? '0 : cnt_q + CntW'(1);
    rdy_en_d = 1'b1;

    // Pop only from a non-empty FIFO; a same-edge push never bypasses to the shadow.
    fifo_pop = wrap && !fifo_empty;
    shadow_d = shadow_q;
    ur_d     = 1'b0;
    if (wrap) begin
      shadow_d = fifo_empty ? '0 : fifo_rdata;
      ur_d     = fifo_empty;
    end

    right_slot = (cnt_q >= CntW'(SLOT_BITS));
    pos        = right_slot ? cnt_q - CntW'(SLOT_BITS) : cnt_q;
    word       = right_slot ? shadow_q.right : shadow_q.left;
    bit_idx    = BitIdxW'(CntW'(SAMPLE_W) - pos);

    lr_d   = right_slot;
    fs_d   = (cnt_q == '0);
    data_d = 1'b0;
    if ((pos >= CntW'(1)) && (pos <= CntW'(SAMPLE_W))) begin
      data_d = word[bit_idx];
    end
  end

  always_ff @(posedge BCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      shadow_q <= '0;
      lr_q     <= 1'b0;
      data_q   <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
      shadow_q <= shadow_d;
      lr_q     <= lr_d;
      data_q   <= data_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end

  assign DAC_LR_CLK  = lr_q;
  assign DAC_DATA    = data_q;
  assign FRAME_START = fs_q;
  assign UNDERRUN    = ur_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: records output streams per frame and compares them
// against hand-derived frame patterns, at default slot width and at SLOT_BITS=17.
module tb_i2s_tx_serializer;

  localparam int NFrm = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] sample_l = '0, sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, dac_lr, dac_data, frame_start, underrun;
  logic [15:0] s17_l = '0, s17_r = '0;
  logic        s17_valid = 1'b0;
  logic        s17_ready, s17_lr, s17_data, s17_fs, s17_ur;

  int n_cmp = 0;
  int n_mis = 0;
  int n_push;
  int cyc;
  int f32, p32, f17, p17;

  logic [63:0] dat_h [NFrm];
  logic [63:0] lr_h  [NFrm];
  logic [63:0] fs_h  [NFrm];
  logic [63:0] ur_h  [NFrm];
  logic [63:0] d17_h [NFrm];
  logic [63:0] lr17_h[NFrm];
  logic [63:0] fs17_h[NFrm];
  int          acc_h [NFrm];

  i2s_tx_serializer dut (
    .BCLK         (clk),
    .RESET_N      (rst_n),
    .SAMPLE_L     (sample_l),
    .SAMPLE_R     (sample_r),
    .SAMPLE_VALID (sample_valid),
    .SAMPLE_READY (sample_ready),
    .DAC_LR_CLK   (dac_lr),
    .DAC_DATA     (dac_data),
    .FRAME_START  (frame_start),
    .UNDERRUN     (underrun)
  );

  i2s_tx_serializer #(
    .SLOT_BITS  (17),
    .FIFO_DEPTH (4)
  ) dut17 (
    .BCLK         (clk),
    .RESET_N      (rst_n),
    .SAMPLE_L     (s17_l),
    .SAMPLE_R     (s17_r),
    .SAMPLE_VALID (s17_valid),
    .SAMPLE_READY (s17_ready),
    .DAC_LR_CLK   (s17_lr),
    .DAC_DATA     (s17_data),
    .FRAME_START  (s17_fs),
    .UNDERRUN     (s17_ur)
  );

  always #5 clk = ~clk;

  // Edge k after release loads counter k mod frame; outputs at negedge k show counter k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  assign f32 = (cyc - 1) / 64;
  assign p32 = (cyc - 1) % 64;
  assign f17 = (cyc - 1) / 34;
  assign p17 = (cyc - 1) % 34;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NFrm; i++) acc_h[i] <= 0;
    end else if (cyc > 0) begin
      if (f32 < NFrm) begin
        dat_h[f32][p32] <= dac_data;
        lr_h[f32][p32]  <= dac_lr;
        fs_h[f32][p32]  <= frame_start;
        ur_h[f32][p32]  <= underrun;
        if (sample_valid && sample_ready) acc_h[f32] <= acc_h[f32] + 1;
      end
      if (f17 < NFrm) begin
        d17_h[f17][p17]  <= s17_data;
        lr17_h[f17][p17] <= s17_lr;
        fs17_h[f17][p17] <= s17_fs;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_pat(input logic [15:0] l, input logic [15:0] r,
                                            input int slot);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      v[1 + i]        = l[15 - i];
      v[slot + 1 + i] = r[15 - i];
    end
    return v;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_edge_count(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  localparam logic [63:0] LrPat32 = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] Bit63   = 64'h8000_0000_0000_0000;

  initial begin
    // Reset state and first edge after release
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_lr", 64'(dac_lr), 64'd0);
    check_eq("rst_data", 64'(dac_data), 64'd0);
    check_eq("rst_fs", 64'(frame_start), 64'd0);
    check_eq("rst_ur", 64'(underrun), 64'd0);
    check_eq("rst_ready", 64'(sample_ready), 64'd0);
    check_eq("rst_ready17", 64'(s17_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_rise", 64'(sample_ready), 64'd1);
    check_eq("first_fs", 64'(frame_start), 64'd1);

    // 0x8001 / 0x7FFE pushed during frame 0, transmitted in frame 1
    sample_l = 16'h8001;
    sample_r = 16'h7FFE;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    run_until(3 * 64);
    check_eq("a_f0_silent", dat_h[0], 64'd0);
    check_eq("a_f1_data", dat_h[1], 64'h0000_FFFC_0001_0002);
    check_eq("a_f2_silent", dat_h[2], 64'd0);
    check_eq("a_f1_lr", lr_h[1], LrPat32);
    check_eq("a_f0_fs", fs_h[0], 64'd1);
    check_eq("a_f1_fs", fs_h[1], 64'd1);
    check_eq("a_f0_ur", ur_h[0], 64'd0);
    check_eq("a_f1_ur", ur_h[1], Bit63);

    // Idle: silence, one underrun per frame
    pulse_reset();
    run_until(3 * 64);
    for (int f = 0; f < 3; f++) begin
      check_eq($sformatf("b_f%0d_data", f), dat_h[f], 64'd0);
      check_eq($sformatf("b_f%0d_ur", f), ur_h[f], Bit63);
      check_eq($sformatf("b_f%0d_lr", f), lr_h[f], LrPat32);
    end

    // Continuous stream of incrementing pairs
    sample_l = 16'h1000;
    sample_r = 16'h2000;
    sample_valid = 1'b1;
    n_push = 0;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      logic go;
      @(negedge clk);
      go = sample_valid && sample_ready;
      if (i == 10) begin
        check_eq("c_full_ready", 64'(sample_ready), 64'd0);
        check_eq("c_accepts", 64'(n_push), 64'd4);
      end
      @(posedge clk);
      #1;
      if (go) begin
        n_push++;
        sample_l = 16'h1000 + 16'(n_push);
        sample_r = 16'h2000 + 16'(n_push);
      end
    end
    sample_valid = 1'b0;
    check_eq("c_acc_f0", 64'(acc_h[0]), 64'd5);
    for (int f = 1; f < 6; f++) begin
      check_eq($sformatf("c_f%0d_data", f), dat_h[f],
               frame_pat(16'h1000 + 16'(f - 1), 16'h2000 + 16'(f - 1), 32));
      check_eq($sformatf("c_acc_f%0d", f), 64'(acc_h[f]), 64'd1);
    end
    for (int f = 0; f < 6; f++) check_eq($sformatf("c_ur_f%0d", f), ur_h[f], 64'd0);

    // Push on the pop edge with FIFO empty
    pulse_reset();
    wait_edge_count(63);
    sample_l = 16'hA5A5;
    sample_r = 16'h5A5A;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    run_until(3 * 64);
    check_eq("d_ur_f0", ur_h[0], Bit63);
    check_eq("d_f1_silent", dat_h[1], 64'd0);
    check_eq("d_f2_data", dat_h[2], frame_pat(16'hA5A5, 16'h5A5A, 32));
    check_eq("d_ur_f1", ur_h[1], 64'd0);

    // Asynchronous reset at counter 40 with three pairs queued
    pulse_reset();
    wait_edge_count(1);
    sample_valid = 1'b1;
    sample_l = 16'h1111;
    sample_r = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sample_l = sample_l + 16'd1;
      sample_r = sample_r + 16'd1;
    end
    sample_valid = 1'b0;
    wait_edge_count(40);
    check_eq("e_pre_lr", 64'(dac_lr), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("e_rst_lr", 64'(dac_lr), 64'd0);
    check_eq("e_rst_data", 64'(dac_data), 64'd0);
    check_eq("e_rst_fs", 64'(frame_start), 64'd0);
    check_eq("e_rst_ur", 64'(underrun), 64'd0);
    check_eq("e_rst_ready", 64'(sample_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_until(2 * 64);
    check_eq("e_f0_fs", fs_h[0], 64'd1);
    check_eq("e_f0_silent", dat_h[0], 64'd0);
    check_eq("e_f0_ur", ur_h[0], Bit63);
    check_eq("e_f1_silent", dat_h[1], 64'd0);

    // SLOT_BITS=17 instance: 34-cycle frame, LSB then LR change
    pulse_reset();
    wait_edge_count(1);
    s17_l = 16'h8001;
    s17_r = 16'h7FFE;
    s17_valid = 1'b1;
    @(posedge clk);
    #1 s17_valid = 1'b0;
    run_until(3 * 34);
    check_eq("f_f0_silent", 64'(d17_h[0][33:0]), 64'd0);
    check_eq("f_f1_data", 64'(d17_h[1][33:0]), 64'h0000_0001_FFF9_0002);
    check_eq("f_f1_lr", 64'(lr17_h[1][33:0]), 64'h0000_0003_FFFE_0000);
    check_eq("f_f1_fs", 64'(fs17_h[1][33:0]), 64'd1);
    check_eq("f_f2_silent", 64'(d17_h[2][33:0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
